cluster_clock_gate_ctrl: RTL and testbench

- Control side of the cluster clock gate: decides when the cluster clock may be stopped and drives the gate cell's enable input.
- Runs on the free-running (ungated) clock.
- Watches cluster activity and handshakes a quiesce request/acknowledge with the cluster before dropping the enable.
- On a wake event, re-enables the clock and signals clock-ready after a fixed settle delay.

---
 rtl/cluster_clock_gate_ctrl.sv | 127 ++++++++++++
 tb/tb_cluster_clock_gate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_clock_gate_ctrl.sv
// Cluster clock gate controller: idle detection, quiesce handshake, gate enable and wake settle.
// Optional gated-cycle statistics counter is built when CLUSTER_CLK_GATE_STATS_EN is defined.
module cluster_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        busy_i,
    input  logic        wake_i,
    input  logic        force_on_i,
    input  logic        gate_ack_i,
    input  logic        stats_clr_i,
    output logic        clk_en_o,
    output logic        gate_req_o,
    output logic        clk_ready_o,
    output logic        gated_o,
    output logic [31:0] gated_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REQ   = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_idle_cnt_next;
    logic [CNT_W-1:0] r_wake_cnt;
    logic [CNT_W-1:0] w_wake_cnt_next;
    logic             w_quiet;

    assign w_quiet = !busy_i && !wake_i && !force_on_i;

    always_comb begin
        w_state_next    = r_state;
        w_idle_cnt_next = r_idle_cnt;
        w_wake_cnt_next = r_wake_cnt;
        case (r_state)
            ST_RUN: begin
                if (!w_quiet) begin
                    w_idle_cnt_next = '0;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_state_next    = ST_REQ;
                    w_idle_cnt_next = '0;
                end else begin
                    w_idle_cnt_next = r_idle_cnt + 1'b1;
                end
            end
            ST_REQ: begin
                // Any activity aborts the request even if the ack arrives in the same cycle.
                if (!w_quiet) begin
                    w_state_next = ST_RUN;
                end else if (gate_ack_i) begin
                    w_state_next = ST_GATED;
                end
            end
            ST_GATED: begin
                if (!w_quiet) begin
                    w_state_next    = ST_WAKE;
                    w_wake_cnt_next = '0;
                end
            end
            ST_WAKE: begin
                if (r_wake_cnt == WAKE_LAST) begin
                    w_state_next    = ST_RUN;
                    w_wake_cnt_next = '0;
                end else begin
                    w_wake_cnt_next = r_wake_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_RUN;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
            clk_en_o    <= 1'b1;
            clk_ready_o <= 1'b1;
            gate_req_o  <= 1'b0;
            gated_o     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idle_cnt  <= w_idle_cnt_next;
            r_wake_cnt  <= w_wake_cnt_next;
            clk_en_o    <= (w_state_next != ST_GATED);
            clk_ready_o <= (w_state_next == ST_RUN) || (w_state_next == ST_REQ);
            gate_req_o  <= (w_state_next == ST_REQ);
            gated_o     <= (w_state_next == ST_GATED);
        end
    end

`ifdef CLUSTER_CLK_GATE_STATS_EN
    logic [31:0] r_gated_cycles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gated_cycles <= '0;
        end else if (stats_clr_i) begin
            r_gated_cycles <= '0;
        end else if ((r_state == ST_GATED) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
            r_gated_cycles <= r_gated_cycles + 32'd1;
        end
    end

    assign gated_cycles_o = r_gated_cycles;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr_i;
    assign gated_cycles_o     = '0;
`endif

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Bench for cluster_clock_gate_ctrl: directed scenarios plus random stimulus against a
// cycle-level behavioural model of idle run length, handshake, gating and settle time.
module tb_cluster_clock_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        busy_i = 1'b1;
    logic        wake_i = 1'b0;
    logic        force_on_i = 1'b0;
    logic        gate_ack_i = 1'b0;
    logic        stats_clr_i = 1'b0;
    logic        clk_en_o;
    logic        gate_req_o;
    logic        clk_ready_o;
    logic        gated_o;
    logic [31:0] gated_cycles_o;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: length of the current quiet run, whether a request is pending,
    // whether the clock is stopped, and how many settle cycles remain after a wake.
    int          m_run;
    bit          m_req;
    bit          m_gated;
    int          m_settle;
    longint      m_stats;

    always #5 clk_i = ~clk_i;

    cluster_clock_gate_ctrl #(
        .IDLE_CYCLES(IDLE),
        .WAKE_CYCLES(WAKE),
        .CNT_W(8)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .busy_i(busy_i),
        .wake_i(wake_i),
        .force_on_i(force_on_i),
        .gate_ack_i(gate_ack_i),
        .stats_clr_i(stats_clr_i),
        .clk_en_o(clk_en_o),
        .gate_req_o(gate_req_o),
        .clk_ready_o(clk_ready_o),
        .gated_o(gated_o),
        .gated_cycles_o(gated_cycles_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_req    = 1'b0;
        m_gated  = 1'b0;
        m_settle = 0;
        m_stats  = 0;
    endtask

    task automatic model_edge(input bit b, input bit w, input bit f, input bit a, input bit c);
        bit q;
        bit was_gated;
        q = !b && !w && !f;
        was_gated = m_gated;
        if (m_gated) begin
            if (!q) begin
                m_gated  = 1'b0;
                m_settle = WAKE;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end else if (m_req) begin
            if (!q) m_req = 1'b0;
            else if (a) begin
                m_req   = 1'b0;
                m_gated = 1'b1;
            end
        end else begin
            m_run = q ? m_run + 1 : 0;
            if (m_run == IDLE) begin
                m_req = 1'b1;
                m_run = 0;
            end
        end
`ifdef CLUSTER_CLK_GATE_STATS_EN
        if (c) m_stats = 0;
        else if (was_gated && m_stats != 64'hFFFF_FFFF) m_stats++;
`else
        if (c || was_gated) m_stats = 0;
`endif
    endtask

    task automatic check_all(input string tag);
        check({tag, ".clk_en"},   {31'd0, clk_en_o},    {31'd0, !m_gated});
        check({tag, ".gate_req"}, {31'd0, gate_req_o},  {31'd0, m_req});
        check({tag, ".ready"},    {31'd0, clk_ready_o}, {31'd0, (!m_gated && m_settle == 0)});
        check({tag, ".gated"},    {31'd0, gated_o},     {31'd0, m_gated});
        check({tag, ".stats"},    gated_cycles_o,       m_stats[31:0]);
    endtask

    // Called at a negedge: drive inputs, advance the model past the next posedge, then compare.
    task automatic step(input string tag, input bit b, input bit w, input bit f,
                        input bit a, input bit c);
        busy_i      = b;
        wake_i      = w;
        force_on_i  = f;
        gate_ack_i  = a;
        stats_clr_i = c;
        model_edge(b, w, f, a, c);
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        busy_i = 1'b1;
        wake_i = 1'b0;
        force_on_i = 1'b0;
        gate_ack_i = 1'b0;
        stats_clr_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic go_gated();
        for (int i = 0; i < IDLE + 1; i++) step("to_gated", 0, 0, 0, 1, 0);
    endtask

    initial begin
        do_reset();
        check_all("reset");

        // Idle count reaches the threshold on the 4th quiet edge, then ack gates one edge later.
        for (int i = 0; i < IDLE - 1; i++) step("idle", 0, 0, 0, 1, 0);
        check("req_early", {31'd0, gate_req_o}, 32'd0);
        step("idle4", 0, 0, 0, 1, 0);
        check("req_rise", {31'd0, gate_req_o}, 32'd1);
        step("gate", 0, 0, 0, 1, 0);
        check("gated_en", {31'd0, clk_en_o}, 32'd0);
        check("gated_st", {31'd0, gated_o}, 32'd1);

        // One wake pulse: enable next edge, ready WAKE edges after that, no regate.
        step("wake_pulse", 0, 1, 0, 0, 0);
        check("wake_en", {31'd0, clk_en_o}, 32'd1);
        check("wake_notready", {31'd0, clk_ready_o}, 32'd0);
        step("settle1", 0, 0, 0, 0, 0);
        step("settle2", 0, 0, 0, 0, 0);
        check("ready_rise", {31'd0, clk_ready_o}, 32'd1);

        // Busy interrupts the quiet run: counting restarts.
        step("busy_hi", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("q3", 0, 0, 0, 0, 0);
        step("busy_blip", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("q_new", 0, 0, 0, 0, 0);
        check("restart_noreq", {31'd0, gate_req_o}, 32'd0);
        step("q_new4", 0, 0, 0, 0, 0);
        check("restart_req", {31'd0, gate_req_o}, 32'd1);

        // Wake and ack together in REQ: abort wins.
        step("abort", 0, 1, 0, 1, 0);
        check("abort_req", {31'd0, gate_req_o}, 32'd0);
        check("abort_en", {31'd0, clk_en_o}, 32'd1);

        // Force-on blocks gating entirely.
        for (int i = 0; i < 100; i++) step("force", 0, 0, 1, 1, 0);
        check("force_noreq", {31'd0, gate_req_o}, 32'd0);

        // Hold GATED for 10 cycles, then clear the statistics.
        go_gated();
        for (int i = 0; i < 10; i++) step("hold", 0, 0, 0, 0, 0);
`ifdef CLUSTER_CLK_GATE_STATS_EN
        check("stats10", gated_cycles_o, 32'd10);
`endif
        step("stats_clr", 0, 0, 0, 0, 1);
        check("stats_zero", gated_cycles_o, 32'd0);

        // Asynchronous reset in GATED re-enables the clock before any edge.
        #2 rst_ni = 1'b0;
        #1;
        check("async_en", {31'd0, clk_en_o}, 32'd1);
        check("async_req", {31'd0, gated_o}, 32'd0);
        do_reset();
        check_all("after_reset");

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
